uart_rx_param: RTL

Parametrised UART receiver, the successor to the fixed 8-bit, 8-clocks-per-bit receiver. It adds configurable data width, bit period, parity and stop bits. Each bit is decided by a 3-sample majority vote at mid-bit, and the block reports framing, parity and overrun errors. Received words go to the consumer through a valid/ready handshake. It sits between the serial rx pin and the byte-stream consumer logic.

---
 rtl/uart_rx_param.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver. It supports 5..9 data bits (LSB first), a configurable
// bit period, optional even or odd parity, and one or two stop bits. Each bit is
// decided by a three-sample majority vote around mid-bit. Words are handed to the
// consumer over a valid/ready handshake, along with frame, parity and overrun flags.
module uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_p0;
    logic                 rx_p1;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 bit_wrap;
    logic                 decide;
    logic                 bit_val;
    logic                 frame_done;
    logic                 handshake;

    // Two of three samples agree: a single-cycle glitch cannot flip the bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Two-flop synchroniser. It resets to the idle line level so that reset is not
    // mistaken for a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    // State register. busy is registered so that it follows the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
        end
    end

    // Next-state logic. The final stop bit returns to IDLE at its decision point,
    // which leaves half a bit of margin before the next start edge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!rx_p1) state_nxt = S_START;
            S_START: begin
                if (decide && bit_val)  state_nxt = S_IDLE;
                else if (bit_wrap)      state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_wrap && bit_idx == LAST_DATA)
                    state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_wrap)   state_nxt = S_STOP;
            S_STOP:   if (frame_done) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Timing strobes derived from the bit counter, plus the voted bit value.
    always_comb begin
        bit_wrap   = (state != S_IDLE) && (cnt == CNT_LAST);
        decide     = (state != S_IDLE) && (cnt == CNT_DEC);
        bit_val    = maj3(smp[1], smp[0], rx_p1);
        frame_done = decide && (state == S_STOP) && (bit_idx == LAST_STOP);
        handshake  = data_valid && data_ready;
    end

    // Bit-period counter, bit index within the current state, and mid-bit samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            smp     <= '0;
        end else begin
            if (state == S_IDLE || state_nxt == S_IDLE || bit_wrap)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state_nxt != state)
                bit_idx <= '0;
            else if (bit_wrap)
                bit_idx <= bit_idx + 4'd1;

            if (cnt == CNT_S0 || cnt == CNT_S1)
                smp <= {smp[0], rx_p1};
        end
    end

    // Data shift register. It is always rewritten by a complete frame before use,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (decide && state == S_DATA)
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
    end

    // Per-frame parity and stop-bit accumulators. They are cleared while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (state == S_IDLE) begin
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (decide) begin
            case (state)
                S_DATA:   par_acc  <= par_acc ^ bit_val;
                S_PARITY: par_bad  <= (par_acc ^ bit_val) != (PARITY == 2);
                S_STOP:   if (!bit_val) stop_bad <= 1'b1;
                default:  ;
            endcase
        end
    end

    // Output word and handshake. A completed frame always loads. overrun is set only
    // when a completed frame replaces an unread word, and it clears on any handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_done) begin
            data_out   <= shreg;
            frame_err  <= stop_bad | ~bit_val;
            parity_err <= (PARITY != 0) && par_bad;
            data_valid <= 1'b1;
            if (handshake)
                overrun <= 1'b0;
            else if (data_valid)
                overrun <= 1'b1;
        end else if (handshake) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
